apb_cfg_master: RTL and testbench

//  APB initiator that turns a simple req/gnt command port into single APB

---
 rtl/apb_cfg_master.sv | 147 ++++++++++++++
 tb/tb_apb_cfg_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_master.sv
// APB initiator: converts a req/gnt command port into single APB transfers,
// one outstanding, with an optional ACCESS-phase timeout.
module apb_cfg_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic                      timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES != 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [31:0]               r_pwdata;
    logic [31:0]               w_pwdata_nxt;
    logic                      r_pwrite;
    logic                      w_pwrite_nxt;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_rvalid;
    logic                      w_rvalid_nxt;
    logic                      r_err;
    logic                      w_err_nxt;
    logic                      r_timeout;
    logic                      w_timeout_nxt;
    logic [31:0]               r_rdata;
    logic [31:0]               w_rdata_nxt;

    assign gnt_o = req_i && (r_state == S_IDLE);

    // State and all registered outputs; async reset aborts any transfer silently.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_psel    <= (w_state_nxt != S_IDLE);
            r_penable <= (w_state_nxt == S_ACCESS);
            r_rvalid  <= w_rvalid_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_pwrite_nxt  = r_pwrite;
        w_rvalid_nxt  = 1'b0;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
        w_rdata_nxt   = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_paddr_nxt  = addr_i;
                    w_pwdata_nxt = wdata_i;
                    w_pwrite_nxt = we_i;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt  = S_IDLE;
                    w_rvalid_nxt = 1'b1;
                    w_err_nxt    = PSLVERR;
                    w_rdata_nxt  = (!r_pwrite && !PSLVERR) ? PRDATA : 32'd0;
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    w_state_nxt   = S_IDLE;
                    w_rvalid_nxt  = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_rdata_nxt   = 32'd0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign rvalid_o  = r_rvalid;
    assign err_o     = r_err;
    assign timeout_o = r_timeout;
    assign rdata_o   = r_rdata;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed self-checking bench for apb_cfg_master with hand-computed expectations.
module tb_apb_cfg_master;

    logic        HCLK;
    logic        HRESET;
    logic        req_i;
    logic        we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        timeout_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    apb_cfg_master #(
        .APB_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .timeout_o (timeout_o),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int cnt_acc;
        int guard;

        HRESET  = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        PRDATA  = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;

        tick(); tick();
        #1;
        chk("rst_psel",    PSEL,     0);
        chk("rst_penable", PENABLE,  0);
        chk("rst_pwrite",  PWRITE,   0);
        chk("rst_rvalid",  rvalid_o, 0);
        chk("rst_err",     err_o,    0);
        chk("rst_paddr",   PADDR,    0);
        chk("rst_rdata",   rdata_o,  0);
        tick();
        HRESET = 1'b0;

        // Zero-wait write.
        tick();
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h020; wdata_i = 32'h1F1F1F1F; PREADY = 1'b1;
        #1;
        chk("w_gnt",  gnt_o, 1);
        chk("w_psel0", PSEL, 0);
        tick(); req_i = 1'b0; #1;
        chk("w_setup_psel",    PSEL,    1);
        chk("w_setup_penable", PENABLE, 0);
        chk("w_setup_pwrite",  PWRITE,  1);
        chk("w_setup_paddr",   PADDR,   32'h020);
        chk("w_setup_pwdata",  PWDATA,  32'h1F1F1F1F);
        tick(); #1;
        chk("w_acc_psel",    PSEL,     1);
        chk("w_acc_penable", PENABLE,  1);
        chk("w_acc_rvalid",  rvalid_o, 0);
        tick(); #1;
        chk("w_rvalid",  rvalid_o,  1);
        chk("w_err",     err_o,     0);
        chk("w_timeout", timeout_o, 0);
        chk("w_rdata",   rdata_o,   0);
        chk("w_psel_end", PSEL,     0);
        tick(); #1;
        chk("w_rvalid_pulse", rvalid_o, 0);

        // Zero-wait read.
        req_i = 1'b1; we_i = 1'b0; addr_i = 12'h004; PRDATA = 32'h00020401;
        #1;
        chk("r_gnt", gnt_o, 1);
        tick(); req_i = 1'b0; #1;
        chk("r_pwrite", PWRITE, 0);
        chk("r_paddr",  PADDR,  32'h004);
        tick(); #1;
        tick(); #1;
        chk("r_rvalid", rvalid_o, 1);
        chk("r_rdata",  rdata_o,  32'h00020401);
        chk("r_err",    err_o,    0);
        tick(); PRDATA = 32'hDEADBEEF; #1;
        chk("r_rdata_hold", rdata_o, 32'h00020401);

        // Read with 5 wait states: PENABLE high for 6 ACCESS cycles, rvalid at t+8.
        PREADY = 1'b0; PRDATA = 32'hA5A50001;
        req_i = 1'b1; we_i = 1'b0; addr_i = 12'h1C8;
        #1;
        chk("ws_gnt", gnt_o, 1);
        tick(); req_i = 1'b0; addr_i = 12'hFFF; #1;
        chk("ws_setup_psel", PSEL, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            PREADY = (i == 5);
            #1;
            chk("ws_acc_psel",    PSEL,     1);
            chk("ws_acc_penable", PENABLE,  1);
            chk("ws_acc_paddr",   PADDR,    32'h1C8);
            chk("ws_acc_rvalid",  rvalid_o, 0);
        end
        tick(); PREADY = 1'b0; #1;
        chk("ws_rvalid", rvalid_o, 1);
        chk("ws_err",    err_o,    0);
        chk("ws_rdata",  rdata_o,  32'hA5A50001);
        chk("ws_psel",   PSEL,     0);

        // Timeout: PREADY never high, 16 ACCESS cycles then err+timeout.
        tick();
        req_i = 1'b1; we_i = 1'b0; addr_i = 12'h010; PRDATA = 32'h12345678;
        #1;
        chk("to_gnt", gnt_o, 1);
        tick(); req_i = 1'b0; #1;
        cnt_acc = 0;
        guard   = 0;
        while (!rvalid_o && guard < 40) begin
            tick(); #1;
            if (PENABLE) cnt_acc++;
            guard++;
        end
        chk("to_seen",    rvalid_o,  1);
        chk("to_acc_cyc", cnt_acc,   16);
        chk("to_err",     err_o,     1);
        chk("to_timeout", timeout_o, 1);
        chk("to_rdata",   rdata_o,   0);
        chk("to_psel",    PSEL,      0);
        tick(); #1;
        chk("to_timeout_pulse", timeout_o, 0);

        // PSLVERR on write with req held: regrant in the rvalid cycle.
        PREADY = 1'b1; PSLVERR = 1'b1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h030; wdata_i = 32'h0000_00FF;
        #1;
        chk("se_gnt0", gnt_o, 1);
        tick(); #1;
        chk("se_busy_gnt1", gnt_o, 0);
        tick(); #1;
        chk("se_busy_gnt2", gnt_o, 0);
        tick(); #1;
        chk("se_rvalid",  rvalid_o,  1);
        chk("se_err",     err_o,     1);
        chk("se_timeout", timeout_o, 0);
        chk("se_regnt",   gnt_o,     1);
        tick(); req_i = 1'b0; #1;
        chk("se2_psel", PSEL, 1);
        tick(); #1;
        tick(); #1;
        chk("se2_rvalid", rvalid_o, 1);
        chk("se2_err",    err_o,    1);
        PSLVERR = 1'b0;

        // Reset during ACCESS: bus drops immediately, no completion.
        tick();
        PREADY = 1'b0;
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h044; wdata_i = 32'h0BAD_F00D;
        #1;
        chk("ra_gnt", gnt_o, 1);
        tick(); req_i = 1'b0; #1;
        tick(); #1;
        chk("ra_acc_penable", PENABLE, 1);
        HRESET = 1'b1;
        #1;
        chk("ra_psel_now",    PSEL,    0);
        chk("ra_penable_now", PENABLE, 0);
        tick();
        HRESET = 1'b0; PREADY = 1'b1;
        #1;
        chk("ra_no_rvalid0", rvalid_o, 0);
        tick(); #1;
        chk("ra_no_rvalid1", rvalid_o, 0);

        // First request after reset release: zero-wait write.
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h020; wdata_i = 32'h1F1F1F1F;
        #1;
        chk("pr_gnt", gnt_o, 1);
        tick(); req_i = 1'b0; #1;
        chk("pr_psel",   PSEL,   1);
        chk("pr_pwrite", PWRITE, 1);
        tick(); #1;
        chk("pr_penable", PENABLE, 1);
        tick(); #1;
        chk("pr_rvalid", rvalid_o, 1);
        chk("pr_err",    err_o,    0);
        chk("pr_rdata",  rdata_o,  0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
